ex_fu_sequencer: RTL and testbench

//  Parametrised execution-stage result sequencer and EX/MEM register. Dispatches each

---
 rtl/ex_stage_pkg.sv | 18 +
 rtl/fu_result_mux.sv | 31 +++
 rtl/ex_fu_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_ex_fu_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execution stage: sequencer FSM state encodings
// and functional-unit index constants.
package ex_stage_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // accepting instructions
        ST_WAIT = 2'd1,  // multi-cycle unit in flight
        ST_HOLD = 2'd2   // multi-cycle result parked while memory stalls
    } seq_state_t;

    // Functional-unit slot assignments
    localparam int FU_ALU = 0;
    localparam int FU_MDU = 1;
    localparam int FU_BMU = 2;
    localparam int FU_CSR = 3;

endpackage

// File: rtl/fu_result_mux.sv
// NUM_FU:1 selector picking one XLEN-wide unit result out of a flat bus.
// An out-of-range select yields zero.
module fu_result_mux #(
    parameter int XLEN   = 32,
    parameter int NUM_FU = 4,
    parameter int SEL_W  = $clog2(NUM_FU)
) (
    input  logic [NUM_FU*XLEN-1:0] data,
    input  logic [SEL_W-1:0]       sel,
    output logic [XLEN-1:0]        result
);

    logic [XLEN-1:0] lane [NUM_FU];

    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_lane
            assign lane[gi] = data[gi*XLEN +: XLEN];
        end
    endgenerate

    // Select the addressed lane; unmatched selects fall through to zero
    always_comb begin
        result = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (sel == SEL_W'(i)) begin
                result = lane[i];
            end
        end
    end

endmodule

// File: rtl/ex_fu_sequencer.sv
// Execution-stage result sequencer and EX/MEM register.
// Dispatches to single-cycle (combinational) or multi-cycle (start/done)
// units, drives the upstream stall, and inserts bubbles.
// Optional watchdog on multi-cycle units: define FU_TIMEOUT_EN.
module ex_fu_sequencer
    import ex_stage_pkg::*;
#(
    parameter int                XLEN        = 32,
    parameter int                NUM_FU      = 4,
    parameter logic [NUM_FU-1:0] MC_MASK     = 4'b0010,
    parameter int                CTRL_W      = 8,
    parameter int                TIMEOUT_CYC = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       busywait_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    input  logic [$clog2(NUM_FU)-1:0]  in_fu_sel_i,
    input  logic [4:0]                 in_rd_i,
    input  logic [XLEN-1:0]            in_pc_i,
    input  logic [1:0]                 in_wb_sel_i,
    input  logic [CTRL_W-1:0]          in_ctrl_i,
    input  logic [NUM_FU*XLEN-1:0]     fu_result_i,
    input  logic [NUM_FU-1:0]          fu_done_i,
    output logic [NUM_FU-1:0]          fu_start_o,
    output logic [NUM_FU-1:0]          fu_abort_o,
    output logic                       stall_o,
    output logic                       fu_timeout_o,
    output logic                       out_valid_o,
    output logic [4:0]                 out_rd_o,
    output logic [XLEN-1:0]            out_pc_o,
    output logic [1:0]                 out_wb_sel_o,
    output logic [CTRL_W-1:0]          out_ctrl_o,
    output logic [XLEN-1:0]            out_result_o
);

    localparam int SEL_W = $clog2(NUM_FU);

    seq_state_t          state_reg, state_next;
    logic [SEL_W-1:0]    sel_reg, sel_next;
    logic [XLEN-1:0]     hold_reg, hold_next;

    logic                out_valid_reg, out_valid_next;
    logic [4:0]          out_rd_reg, out_rd_next;
    logic [XLEN-1:0]     out_pc_reg, out_pc_next;
    logic [1:0]          out_wb_sel_reg, out_wb_sel_next;
    logic [CTRL_W-1:0]   out_ctrl_reg, out_ctrl_next;
    logic [XLEN-1:0]     out_result_reg, out_result_next;

    logic [XLEN-1:0]     live_result;
    logic [XLEN-1:0]     held_result;
    logic [NUM_FU-1:0]   onehot_in;
    logic [NUM_FU-1:0]   onehot_q;
    logic                in_range;
    logic                in_is_mc;
    logic                done_q;
    logic                timeout_hit;

    // Result from the unit addressed by the incoming instruction
    fu_result_mux #(.XLEN(XLEN), .NUM_FU(NUM_FU), .SEL_W(SEL_W)) u_live_mux (
        .data   (fu_result_i),
        .sel    (in_fu_sel_i),
        .result (live_result)
    );

    // Result from the multi-cycle unit currently in flight
    fu_result_mux #(.XLEN(XLEN), .NUM_FU(NUM_FU), .SEL_W(SEL_W)) u_held_mux (
        .data   (fu_result_i),
        .sel    (sel_reg),
        .result (held_result)
    );

    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_onehot
            assign onehot_in[gi] = (in_fu_sel_i == SEL_W'(gi));
            assign onehot_q[gi]  = (sel_reg == SEL_W'(gi));
        end
    endgenerate

    assign in_range = (int'(in_fu_sel_i) < NUM_FU);
    assign in_is_mc = in_range && MC_MASK[in_fu_sel_i];
    assign done_q   = fu_done_i[sel_reg];

`ifdef FU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] count_reg;

    // Counts consecutive WAIT cycles; restarts on every entry and exit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_reg <= '0;
        end else if ((state_reg == ST_WAIT) && (state_next == ST_WAIT)) begin
            count_reg <= count_reg + 1'b1;
        end else begin
            count_reg <= '0;
        end
    end

    assign timeout_hit = (state_reg == ST_WAIT) && !done_q &&
                         (count_reg == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign timeout_hit        = 1'b0;
`endif

    // FSM and EX/MEM register state update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            sel_reg        <= '0;
            hold_reg       <= '0;
            out_valid_reg  <= 1'b0;
            out_rd_reg     <= '0;
            out_pc_reg     <= '0;
            out_wb_sel_reg <= '0;
            out_ctrl_reg   <= '0;
            out_result_reg <= '0;
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            hold_reg       <= hold_next;
            out_valid_reg  <= out_valid_next;
            out_rd_reg     <= out_rd_next;
            out_pc_reg     <= out_pc_next;
            out_wb_sel_reg <= out_wb_sel_next;
            out_ctrl_reg   <= out_ctrl_next;
            out_result_reg <= out_result_next;
        end
    end

    // Next-state, EX/MEM next contents, and handshake/stall outputs
    always_comb begin
        state_next      = state_reg;
        sel_next        = sel_reg;
        hold_next       = hold_reg;
        out_valid_next  = out_valid_reg;
        out_rd_next     = out_rd_reg;
        out_pc_next     = out_pc_reg;
        out_wb_sel_next = out_wb_sel_reg;
        out_ctrl_next   = out_ctrl_reg;
        out_result_next = out_result_reg;
        fu_start_o      = '0;
        fu_abort_o      = '0;
        stall_o         = 1'b0;
        fu_timeout_o    = 1'b0;

        if (flush_i) begin
            // Flush wins over memory stall: clear EX/MEM and cancel any in-flight unit
            out_valid_next  = 1'b0;
            out_rd_next     = '0;
            out_pc_next     = '0;
            out_wb_sel_next = '0;
            out_ctrl_next   = '0;
            out_result_next = '0;
            if (state_reg != ST_IDLE) begin
                fu_abort_o = onehot_q;
            end
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!busywait_i) begin
                        if (in_valid_i && in_is_mc) begin
                            fu_start_o      = onehot_in;
                            stall_o         = 1'b1;
                            sel_next        = in_fu_sel_i;
                            state_next      = ST_WAIT;
                            out_valid_next  = 1'b0;
                            out_rd_next     = '0;
                            out_pc_next     = '0;
                            out_wb_sel_next = '0;
                            out_ctrl_next   = '0;
                            out_result_next = '0;
                        end else if (in_valid_i && in_range) begin
                            out_valid_next  = 1'b1;
                            out_rd_next     = in_rd_i;
                            out_pc_next     = in_pc_i;
                            out_wb_sel_next = in_wb_sel_i;
                            out_ctrl_next   = in_ctrl_i;
                            out_result_next = live_result;
                        end else begin
                            out_valid_next  = 1'b0;
                            out_rd_next     = '0;
                            out_pc_next     = '0;
                            out_wb_sel_next = '0;
                            out_ctrl_next   = '0;
                            out_result_next = '0;
                        end
                    end
                end

                ST_WAIT: begin
                    // in_* are held stable upstream, so they still describe this op
                    if (done_q && !busywait_i) begin
                        out_valid_next  = 1'b1;
                        out_rd_next     = in_rd_i;
                        out_pc_next     = in_pc_i;
                        out_wb_sel_next = in_wb_sel_i;
                        out_ctrl_next   = in_ctrl_i;
                        out_result_next = held_result;
                        state_next      = ST_IDLE;
                    end else if (done_q) begin
                        stall_o    = 1'b1;
                        hold_next  = held_result;
                        state_next = ST_HOLD;
                    end else begin
                        stall_o = 1'b1;
                        if (timeout_hit) begin
                            fu_abort_o   = onehot_q;
                            fu_timeout_o = 1'b1;
                            state_next   = ST_IDLE;
                        end
                        if (!busywait_i) begin
                            out_valid_next  = 1'b0;
                            out_rd_next     = '0;
                            out_pc_next     = '0;
                            out_wb_sel_next = '0;
                            out_ctrl_next   = '0;
                            out_result_next = '0;
                        end
                    end
                end

                ST_HOLD: begin
                    // Stall drops on the release edge so upstream advances exactly once
                    stall_o = busywait_i;
                    if (!busywait_i) begin
                        out_valid_next  = 1'b1;
                        out_rd_next     = in_rd_i;
                        out_pc_next     = in_pc_i;
                        out_wb_sel_next = in_wb_sel_i;
                        out_ctrl_next   = in_ctrl_i;
                        out_result_next = hold_reg;
                        state_next      = ST_IDLE;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid_o  = out_valid_reg;
    assign out_rd_o     = out_rd_reg;
    assign out_pc_o     = out_pc_reg;
    assign out_wb_sel_o = out_wb_sel_reg;
    assign out_ctrl_o   = out_ctrl_reg;
    assign out_result_o = out_result_reg;

endmodule

// File: tb/tb_ex_fu_sequencer.sv
// Self-checking bench for ex_fu_sequencer: table of single-cycle vectors
// followed by hand-written multi-cycle sequences.
module tb_ex_fu_sequencer;

    localparam int XLEN   = 32;
    localparam int NUM_FU = 4;
    localparam int CTRL_W = 8;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   busywait_i;
    logic                   flush_i;
    logic                   in_valid_i;
    logic [1:0]             in_fu_sel_i;
    logic [4:0]             in_rd_i;
    logic [XLEN-1:0]        in_pc_i;
    logic [1:0]             in_wb_sel_i;
    logic [CTRL_W-1:0]      in_ctrl_i;
    logic [NUM_FU*XLEN-1:0] fu_result_i;
    logic [NUM_FU-1:0]      fu_done_i;
    logic [NUM_FU-1:0]      fu_start_o;
    logic [NUM_FU-1:0]      fu_abort_o;
    logic                   stall_o;
    logic                   fu_timeout_o;
    logic                   out_valid_o;
    logic [4:0]             out_rd_o;
    logic [XLEN-1:0]        out_pc_o;
    logic [1:0]             out_wb_sel_o;
    logic [CTRL_W-1:0]      out_ctrl_o;
    logic [XLEN-1:0]        out_result_o;

    ex_fu_sequencer #(
        .XLEN(XLEN), .NUM_FU(NUM_FU), .MC_MASK(4'b0010),
        .CTRL_W(CTRL_W), .TIMEOUT_CYC(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .busywait_i(busywait_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_fu_sel_i(in_fu_sel_i), .in_rd_i(in_rd_i),
        .in_pc_i(in_pc_i), .in_wb_sel_i(in_wb_sel_i), .in_ctrl_i(in_ctrl_i),
        .fu_result_i(fu_result_i), .fu_done_i(fu_done_i),
        .fu_start_o(fu_start_o), .fu_abort_o(fu_abort_o), .stall_o(stall_o),
        .fu_timeout_o(fu_timeout_o), .out_valid_o(out_valid_o), .out_rd_o(out_rd_o),
        .out_pc_o(out_pc_o), .out_wb_sel_o(out_wb_sel_o), .out_ctrl_o(out_ctrl_o),
        .out_result_o(out_result_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        valid;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] res;
        logic        busy;
        logic        flush;
        logic        exp_valid;
        logic [4:0]  exp_rd;
        logic [31:0] exp_pc;
        logic [31:0] exp_result;
        logic [7:0]  exp_ctrl;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_res(input int idx, input logic [31:0] val);
        fu_result_i[idx*XLEN +: XLEN] = val;
    endtask

    task automatic set_in(input logic v, input logic [1:0] s, input logic [4:0] rd,
                          input logic [31:0] pc);
        in_valid_i  = v;
        in_fu_sel_i = s;
        in_rd_i     = rd;
        in_pc_i     = pc;
    endtask

    task automatic clear_in();
        set_in(1'b0, 2'd0, 5'd0, 32'd0);
        busywait_i = 1'b0;
        flush_i    = 1'b0;
        fu_done_i  = '0;
    endtask

    initial begin
        rst_i       = 1'b1;
        in_wb_sel_i = 2'b01;
        in_ctrl_i   = 8'h3C;
        fu_result_i = '0;
        clear_in();

        vecs[0] = '{1'b1, 2'd0, 5'd5,  32'h1000, 32'h0000_1234, 1'b0, 1'b0,
                    1'b1, 5'd5,  32'h1000, 32'h0000_1234, 8'h3C};
        vecs[1] = '{1'b0, 2'd0, 5'd6,  32'h1004, 32'h0000_5555, 1'b0, 1'b0,
                    1'b0, 5'd0,  32'h0,    32'h0,         8'h00};
        vecs[2] = '{1'b1, 2'd2, 5'd7,  32'h1008, 32'hA5A5_0002, 1'b0, 1'b0,
                    1'b1, 5'd7,  32'h1008, 32'hA5A5_0002, 8'h3C};
        vecs[3] = '{1'b1, 2'd3, 5'd8,  32'h100C, 32'h0000_7777, 1'b1, 1'b0,
                    1'b1, 5'd7,  32'h1008, 32'hA5A5_0002, 8'h3C};
        vecs[4] = '{1'b1, 2'd0, 5'd9,  32'h1010, 32'h0000_9999, 1'b0, 1'b1,
                    1'b0, 5'd0,  32'h0,    32'h0,         8'h00};
        vecs[5] = '{1'b1, 2'd3, 5'd31, 32'h1014, 32'hFFFF_FFFF, 1'b0, 1'b0,
                    1'b1, 5'd31, 32'h1014, 32'hFFFF_FFFF, 8'h3C};

        // Reset state
        step();
        step();
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_result", 64'(out_result_o), 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_start", 64'(fu_start_o), 64'd0);
        chk("rst_abort", 64'(fu_abort_o), 64'd0);
        chk("rst_timeout", 64'(fu_timeout_o), 64'd0);
        rst_i = 1'b0;

        // Single-cycle vectors from IDLE
        for (int i = 0; i < 6; i++) begin
            for (int u = 0; u < NUM_FU; u++) set_res(u, 32'hBAD0_0000 + 32'(u));
            set_res(int'(vecs[i].sel), vecs[i].res);
            set_in(vecs[i].valid, vecs[i].sel, vecs[i].rd, vecs[i].pc);
            busywait_i = vecs[i].busy;
            flush_i    = vecs[i].flush;
            #2;
            chk($sformatf("v%0d_stall", i), 64'(stall_o), 64'd0);
            step();
            chk($sformatf("v%0d_valid", i), 64'(out_valid_o), 64'(vecs[i].exp_valid));
            chk($sformatf("v%0d_rd", i), 64'(out_rd_o), 64'(vecs[i].exp_rd));
            chk($sformatf("v%0d_pc", i), 64'(out_pc_o), 64'(vecs[i].exp_pc));
            chk($sformatf("v%0d_result", i), 64'(out_result_o), 64'(vecs[i].exp_result));
            chk($sformatf("v%0d_ctrl", i), 64'(out_ctrl_o), 64'(vecs[i].exp_ctrl));
        end
        clear_in();
        step();

        // MDU op, done 4 cycles after start; early and foreign done ignored
        set_in(1'b1, 2'd1, 5'd9, 32'h200);
        fu_done_i = 4'b0010;
        #2;
        chk("mdu_start", 64'(fu_start_o), 64'h2);
        chk("mdu_stall0", 64'(stall_o), 64'd1);
        step();
        chk("mdu_bubble0", 64'(out_valid_o), 64'd0);
        for (int k = 1; k <= 3; k++) begin
            fu_done_i = (k == 1) ? 4'b1000 : 4'b0000;
            #2;
            chk($sformatf("mdu_stall%0d", k), 64'(stall_o), 64'd1);
            chk($sformatf("mdu_nostart%0d", k), 64'(fu_start_o), 64'd0);
            step();
            chk($sformatf("mdu_bubble%0d", k), 64'({out_valid_o, out_rd_o}), 64'd0);
        end
        fu_done_i = 4'b0010;
        set_res(1, 32'hCAFE_F00D);
        #2;
        chk("mdu_stall_done", 64'(stall_o), 64'd0);
        step();
        chk("mdu_valid", 64'(out_valid_o), 64'd1);
        chk("mdu_rd", 64'(out_rd_o), 64'd9);
        chk("mdu_pc", 64'(out_pc_o), 64'h200);
        chk("mdu_result", 64'(out_result_o), 64'hCAFE_F00D);
        clear_in();
        step();

        // MDU done while memory stalls for 3 cycles -> HOLD
        set_in(1'b1, 2'd1, 5'd10, 32'h300);
        step();
        #2;
        chk("hold_wait_stall", 64'(stall_o), 64'd1);
        step();
        fu_done_i  = 4'b0010;
        busywait_i = 1'b1;
        #2;
        chk("hold_done_stall", 64'(stall_o), 64'd1);
        step();
        chk("hold_frozen0", 64'(out_valid_o), 64'd0);
        fu_done_i = 4'b0000;
        set_res(1, 32'hDEAD_BEEF);
        for (int k = 1; k <= 2; k++) begin
            #2;
            chk($sformatf("hold_stall%0d", k), 64'(stall_o), 64'd1);
            step();
            chk($sformatf("hold_frozen%0d", k), 64'(out_valid_o), 64'd0);
        end
        busywait_i = 1'b0;
        step();
        chk("hold_valid", 64'(out_valid_o), 64'd1);
        chk("hold_rd", 64'(out_rd_o), 64'd10);
        chk("hold_result", 64'(out_result_o), 64'hCAFE_F00D);
        clear_in();
        step();

        // Flush in the 2nd WAIT cycle; later done ignored
        set_in(1'b1, 2'd1, 5'd11, 32'h400);
        step();
        step();
        flush_i = 1'b1;
        #2;
        chk("flush_abort", 64'(fu_abort_o), 64'h2);
        chk("flush_stall", 64'(stall_o), 64'd0);
        step();
        chk("flush_valid", 64'(out_valid_o), 64'd0);
        clear_in();
        fu_done_i = 4'b0010;
        #2;
        chk("flush_after_stall", 64'(stall_o), 64'd0);
        chk("flush_after_abort", 64'(fu_abort_o), 64'd0);
        step();
        chk("flush_late_done", 64'(out_valid_o), 64'd0);
        clear_in();

        // Back-to-back ALU, MDU, ALU keeps order
        set_res(0, 32'h11);
        set_in(1'b1, 2'd0, 5'd1, 32'h500);
        step();
        chk("b2b_rd1", 64'(out_rd_o), 64'd1);
        set_in(1'b1, 2'd1, 5'd2, 32'h504);
        #2;
        chk("b2b_mdu_stall", 64'(stall_o), 64'd1);
        step();
        chk("b2b_bubble", 64'(out_valid_o), 64'd0);
        fu_done_i = 4'b0010;
        set_res(1, 32'h22);
        step();
        chk("b2b_rd2", 64'(out_rd_o), 64'd2);
        chk("b2b_res2", 64'(out_result_o), 64'h22);
        fu_done_i = 4'b0000;
        set_res(0, 32'h33);
        set_in(1'b1, 2'd0, 5'd3, 32'h508);
        step();
        chk("b2b_rd3", 64'(out_rd_o), 64'd3);
        chk("b2b_res3", 64'(out_result_o), 64'h33);
        clear_in();
        step();

        // Reset mid-operation: no abort, IDLE afterwards
        set_in(1'b1, 2'd1, 5'd12, 32'h600);
        step();
        rst_i = 1'b1;
        #2;
        chk("rst_mid_abort", 64'(fu_abort_o), 64'd0);
        step();
        rst_i = 1'b0;
        set_res(0, 32'h44);
        set_in(1'b1, 2'd0, 5'd4, 32'h604);
        #2;
        chk("rst_mid_idle", 64'(stall_o), 64'd0);
        step();
        chk("rst_mid_rd", 64'(out_rd_o), 64'd4);
        clear_in();
        step();

`ifdef FU_TIMEOUT_EN
        // Watchdog: done never arrives, abort at WAIT cycle 8
        set_in(1'b1, 2'd1, 5'd13, 32'h700);
        step();
        for (int k = 1; k <= 7; k++) begin
            #2;
            chk($sformatf("to_quiet%0d", k), 64'(fu_timeout_o), 64'd0);
            step();
        end
        #2;
        chk("to_pulse", 64'(fu_timeout_o), 64'd1);
        chk("to_abort", 64'(fu_abort_o), 64'h2);
        step();
        chk("to_bubble", 64'(out_valid_o), 64'd0);
        clear_in();
        #2;
        chk("to_idle", 64'(stall_o), 64'd0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
